b_to_f_scheduler: RTL

Shares the single `b_to_f` frequency calculator among the four DDS channels, each running at its own RF harmonic. On every new magnetic-field sample it runs one calculation per enabled channel, in channel order. Each result goes to that channel's `dds_slave` frequency register, and the channel's `phase_adj` instance gets a start pulse. It sits between the field-sample source and the `b_to_f` / `dds_slave` / `phase_adj` group on the DDS clock domain.

---
 rtl/b_to_f_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/b_to_f_scheduler.sv
// rtl/b_to_f_scheduler.sv - time-shares one b_to_f calculator across the DDS channels
module b_to_f_scheduler #(
  parameter int CH_NUM       = 4,
  parameter int CALC_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          b_field,
  input  logic                 b_valid,
  input  logic [CH_NUM*8-1:0]  k_coeff_ch,
  input  logic [CH_NUM-1:0]    ch_enable,
  input  logic                 err_clr,
  output logic                 calc_start,
  output logic [31:0]          calc_b_field,
  output logic [7:0]           calc_k_coeff,
  input  logic [31:0]          calc_freq,
  input  logic                 calc_ready,
  output logic [CH_NUM*32-1:0] freq_out,
  output logic [CH_NUM-1:0]    freq_update,
  output logic [CH_NUM-1:0]    phase_start,
  output logic                 busy,
  output logic                 cycle_done,
  output logic                 err_timeout,
  output logic                 overrun
);
  localparam int CW = $clog2(CALC_TIMEOUT + 1);
  localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, APPLY} state_t;
  state_t state, state_nxt;

  logic [31:0]       cur_field, buf_field;
  logic [CH_NUM-1:0] pending, buf_en, pend_rest, ch_onehot;
  logic              buf_valid;
  logic [IW-1:0]     sel_idx, ch_q;
  logic [7:0]        k_q;
  logic [7:0]        k_arr [CH_NUM];
  logic [31:0]       freq_q [CH_NUM];
  logic [CW-1:0]     wait_cnt;
  logic              timeout_hit;
  logic              err_q, ovr_q;

  // lowest pending channel is serviced first
  always_comb begin
    sel_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      k_arr[i] = k_coeff_ch[i*8 +: 8];
    end
  end

  assign ch_onehot   = CH_NUM'(1) << ch_q;
  assign pend_rest   = pending & ~ch_onehot;
  assign timeout_hit = (state == WAIT) && !calc_ready && (wait_cnt == CW'(CALC_TIMEOUT));

  always_comb begin
    state_nxt   = state;
    calc_start  = 1'b0;
    busy        = 1'b1;
    cycle_done  = 1'b0;
    freq_update = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (buf_valid) begin
          if (|buf_en) state_nxt = START;
        end else if (b_valid && |ch_enable) begin
          state_nxt = START;
        end
      end
      START: begin
        calc_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (calc_ready) begin
          state_nxt = APPLY;
        end else if (timeout_hit) begin
          cycle_done = ~|pend_rest;
          state_nxt  = (|pend_rest) ? START : IDLE;
        end
      end
      APPLY: begin
        freq_update = ch_onehot;
        cycle_done  = ~|pend_rest;
        state_nxt   = (|pend_rest) ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign phase_start  = freq_update;
  assign calc_b_field = cur_field;
  assign calc_k_coeff = (state == START) ? k_arr[sel_idx] : k_q;
  assign err_timeout  = err_q;
  assign overrun      = ovr_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_freq
    assign freq_out[g*32 +: 32] = freq_q[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_field <= '0;
      pending   <= '0;
      buf_field <= '0;
      buf_en    <= '0;
      buf_valid <= 1'b0;
      ch_q      <= '0;
      k_q       <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) freq_q[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (buf_valid) begin
            cur_field <= buf_field;
            pending   <= buf_en;
          end else if (b_valid) begin
            cur_field <= b_field;
            pending   <= ch_enable;
          end
        end
        START: begin
          ch_q     <= sel_idx;
          k_q      <= k_arr[sel_idx];
          wait_cnt <= CW'(1);
        end
        WAIT: begin
          if (!calc_ready) begin
            if (timeout_hit) pending  <= pend_rest;
            else             wait_cnt <= wait_cnt + CW'(1);
          end
        end
        APPLY:   pending <= pend_rest;
        default: pending <= '0;
      endcase

      // word is captured on the ready edge so it is valid during APPLY
      if (state == WAIT && calc_ready) freq_q[ch_q] <= calc_freq;

      if (b_valid && (state != IDLE || buf_valid)) begin
        buf_field <= b_field;
        buf_en    <= ch_enable;
        buf_valid <= 1'b1;
      end else if (state == IDLE) begin
        buf_valid <= 1'b0;
      end

      ovr_q <= (b_valid && state != IDLE && buf_valid) | (ovr_q & ~err_clr);
      err_q <= timeout_hit | (err_q & ~err_clr);
    end
  end
endmodule
